// File: rtl/seqdet_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seqdet_pkg
// Brief   : Shared constants, overlap-mode encoding and width helper for the
//           parametrised serial sequence detector.
// Rev     : 1.0
// ============================================================================
package seqdet_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic {
        OVL_OFF = 1'b0,
        OVL_ON  = 1'b1
    } ovl_mode_e;

    // cfg_len must hold values 0..MAX_LEN inclusive.
    function automatic int calc_lw(input int max_len);
        return $clog2(max_len) + 1;
    endfunction

endpackage : seqdet_pkg
`default_nettype wire

// File: rtl/seqdet_cmp.sv
`default_nettype none
// ============================================================================
// Module  : seqdet_cmp
// Brief   : Combinational masked compare of the {history, data_in} word
//           against the pattern over the low i_len bits.
// Rev     : 1.0
// ============================================================================
module seqdet_cmp
    import seqdet_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LW      = calc_lw(DEF_MAX_LEN)
)(
    input  logic [MAX_LEN-1:0] i_word,
    input  logic [MAX_LEN-1:0] i_pattern,
    input  logic [LW-1:0]      i_len,
    output logic               o_hit
);

    logic [MAX_LEN-1:0] w_mask;

    always_comb begin
        w_mask = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            w_mask[k] = (k < int'(i_len));
        end
    end

    assign o_hit = (((i_word ^ i_pattern) & w_mask) == '0);

endmodule : seqdet_cmp
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module  : seq_detector_param
// Brief   : Runtime-configurable serial sequence detector with shadow config,
//           Mealy match, registered match and optional saturating counter
//           (counter and match_count port present only with SEQDET_COUNT_EN).
// Rev     : 1.0
// ============================================================================
module seq_detector_param
    import seqdet_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LW      = calc_lw(MAX_LEN),
    parameter int CNT_W   = DEF_CNT_W
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    input  logic               data_valid,
    input  logic               data_in,
    output logic               match,
    output logic               match_q
`ifdef SEQDET_COUNT_EN
    ,
    output logic [CNT_W-1:0]   match_count
`endif
);

    localparam logic [LW-1:0] C_MAX_LEN  = LW'(MAX_LEN);
    localparam logic [LW-1:0] C_FILL_MAX = LW'(MAX_LEN - 1);

    logic [MAX_LEN-1:0] r_pat;
    logic [LW-1:0]      r_len;
    ovl_mode_e          r_ovl;
    logic [MAX_LEN-2:0] r_hist;
    logic [LW-1:0]      r_fill;
    logic               r_match_q;

    logic [MAX_LEN-1:0] w_word;
    logic [LW-1:0]      w_len_in;
    logic               w_hit;
    logic               w_fill_ok;
    logic               w_match;

    assign w_word   = {r_hist, data_in};
    assign w_len_in = (cfg_len > C_MAX_LEN) ? C_MAX_LEN : cfg_len;

    seqdet_cmp #(
        .MAX_LEN (MAX_LEN),
        .LW      (LW)
    ) u_cmp (
        .i_word    (w_word),
        .i_pattern (r_pat),
        .i_len     (r_len),
        .o_hit     (w_hit)
    );

    // r_len - 1 wraps when r_len is 0, but that case is already gated off.
    assign w_fill_ok = (r_fill >= (r_len - LW'(1)));
    assign w_match   = data_valid & ~cfg_load & (r_len != '0) & w_fill_ok & w_hit;
    assign match     = w_match;
    assign match_q   = r_match_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pat     <= '0;
            r_len     <= '0;
            r_ovl     <= OVL_ON;
            r_hist    <= '0;
            r_fill    <= '0;
            r_match_q <= 1'b0;
        end else begin
            r_match_q <= w_match;
            if (cfg_load) begin
                r_pat  <= cfg_pattern;
                r_len  <= w_len_in;
                r_ovl  <= ovl_mode_e'(cfg_overlap);
                r_hist <= '0;
                r_fill <= '0;
            end else if (data_valid) begin
                if (w_match && (r_ovl == OVL_OFF)) begin
                    r_hist <= '0;
                    r_fill <= '0;
                end else begin
                    r_hist <= w_word[MAX_LEN-2:0];
                    if (r_fill != C_FILL_MAX) begin
                        r_fill <= r_fill + LW'(1);
                    end
                end
            end
        end
    end

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign match_count = r_cnt;
`endif

endmodule : seq_detector_param
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_detector_param
// Brief   : Scoreboard bench for seq_detector_param (default and 2-bit count).
// Rev     : 1.0
// ============================================================================
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       data_valid;
    logic       data_in;
    logic       match, match_q, match_s, match_q_s;
`ifdef SEQDET_COUNT_EN
    logic [15:0] cnt;
    logic [1:0]  cnt_s;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    logic prev_exp = 1'b0;
    int   exp_cnt  = 0;
    logic sb_q[$];

    always #5 clk = ~clk;

    seq_detector_param dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .data_valid  (data_valid),
        .data_in     (data_in),
        .match       (match),
        .match_q     (match_q)
`ifdef SEQDET_COUNT_EN
        ,.match_count (cnt)
`endif
    );

    seq_detector_param #(.CNT_W(2)) dut_s (
        .clk         (clk),
        .rst         (rst),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .data_valid  (data_valid),
        .data_in     (data_in),
        .match       (match_s),
        .match_q     (match_q_s)
`ifdef SEQDET_COUNT_EN
        ,.match_count (cnt_s)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check_counts();
`ifdef SEQDET_COUNT_EN
        check("count", 32'(cnt), 32'(sat(exp_cnt, 16)));
        check("count_w2", 32'(cnt_s), 32'(sat(exp_cnt, 2)));
`endif
    endtask

    // One clock of stimulus; expected match queued at drive, checked before the edge.
    task automatic step(input logic v, input logic d, input logic ld, input logic e);
        logic got;
        @(negedge clk);
        data_valid = v;
        data_in    = d;
        cfg_load   = ld;
        sb_q.push_back(e);
        #2;
        got = sb_q.pop_front();
        check("match", 32'(match), 32'(got));
        check("match_w2", 32'(match_s), 32'(got));
        check("match_q", 32'(match_q), 32'(prev_exp));
        check("match_q_w2", 32'(match_q_s), 32'(prev_exp));
        check_counts();
        prev_exp = got;
        if (got) exp_cnt++;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        step(1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    // Sends n bits MSB-first; exp bit n-1-i is the expected match for bit i.
    task automatic send(input logic [7:0] bits, input int n, input logic [7:0] exp);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, bits[i], 1'b0, exp[i]);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_match"}, 32'(match), 32'(0));
        check({tag, "_match_q"}, 32'(match_q), 32'(0));
        check({tag, "_match_q_w2"}, 32'(match_q_s), 32'(0));
`ifdef SEQDET_COUNT_EN
        check({tag, "_count"}, 32'(cnt), 32'(0));
        check({tag, "_count_w2"}, 32'(cnt_s), 32'(0));
`endif
    endtask

    initial begin
        rst = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
        cfg_overlap = 1'b0; data_valid = 1'b0; data_in = 1'b0;
        #7;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b1;

        // Detector is disabled until configured.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // 1010, overlapping.
        load(8'b0000_1010, 4'd4, 1'b1);
        send(8'b1010_1010, 8, 8'b0001_0101);

        // 1010, non-overlapping.
        load(8'b0000_1010, 4'd4, 1'b0);
        send(8'b1010_1010, 8, 8'b0001_0001);

        // 0xA5 with two invalid cycles between bits 3 and 4.
        load(8'hA5, 4'd8, 1'b1);
        send(8'b0000_1010, 4, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send(8'b0000_0101, 4, 8'b0000_0001);

        // Oversized length clamps to MAX_LEN.
        load(8'hA5, 4'd15, 1'b1);
        send(8'hA5, 8, 8'b0000_0001);

        // Single-bit pattern, then disabled.
        load(8'b0000_0001, 4'd1, 1'b1);
        send(8'b0000_1101, 4, 8'b0000_1101);
        load(8'b0000_0001, 4'd0, 1'b1);
        send(8'b0000_0101, 3, 8'h00);

        // Counter saturation on the 2-bit instance.
        load(8'b0000_0001, 4'd1, 1'b1);
        send(8'b0011_1111, 6, 8'b0011_1111);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-pattern.
        load(8'b0000_1010, 4'd4, 1'b1);
        send(8'b0000_0101, 3, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_state("midrst");
        @(posedge clk);
        #1;
        check_reset_state("midrst_held");
        sb_q.delete();
        prev_exp = 1'b0;
        exp_cnt  = 0;
        @(negedge clk);
        rst = 1'b1;
        data_valid = 1'b0;
        load(8'b0000_1010, 4'd4, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_seq_detector_param
`default_nettype wire
